// File: rtl/reg_wb_queue.sv
// Write-back queue feeding the register-file write port, with bypass lookup.
// Define WBQ_BYPASS_EN to build the bypass compare logic.
module reg_wb_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mem_valid,
  output logic          mem_ready,
  input  logic [4:0]    mem_addr,
  input  logic [31:0]   mem_data,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [4:0]    alu_addr,
  input  logic [31:0]   alu_data,
  output logic          regWr,
  output logic [4:0]    addrWr,
  output logic [31:0]   wr_data,
  input  logic [4:0]    byp_addr0,
  input  logic [4:0]    byp_addr1,
  output logic          byp_hit0,
  output logic          byp_hit1,
  output logic [31:0]   byp_data0,
  output logic [31:0]   byp_data1,
  output logic [CW-1:0] count
);

  localparam int AW = CW - 1;

  logic [4:0]    q_addr [DEPTH];
  logic [31:0]   q_data [DEPTH];
  logic [AW-1:0] rptr;
  logic [AW-1:0] wptr;
  logic [CW-1:0] cnt;
  logic          mem_push;
  logic          alu_push;
  logic          pop;

  // MEM owns the last free slot; free space ignores a same-cycle pop
  assign mem_ready = rst_n && (cnt < CW'(DEPTH));
  assign alu_ready = rst_n &&
    ((cnt <= CW'(DEPTH - 2)) ||
     ((cnt < CW'(DEPTH)) && !mem_valid));

  assign mem_push = mem_valid && mem_ready &&
    (mem_addr != 5'd0);
  assign alu_push = alu_valid && alu_ready &&
    (alu_addr != 5'd0);
  assign pop   = (cnt != '0);
  assign count = cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rptr    <= '0;
      wptr    <= '0;
      cnt     <= '0;
      regWr   <= 1'b0;
      addrWr  <= '0;
      wr_data <= '0;
    end else begin
      if (pop) begin
        regWr   <= 1'b1;
        addrWr  <= q_addr[rptr];
        wr_data <= q_data[rptr];
        rptr    <= rptr + AW'(1);
      end else begin
        regWr <= 1'b0;
      end
      wptr <= wptr + AW'(mem_push) + AW'(alu_push);
      cnt  <= cnt + CW'(mem_push) + CW'(alu_push)
            - CW'(pop);
    end
  end

  // MEM lands first so it is the older of a same-edge pair
  always_ff @(posedge clk) begin
    if (mem_push) begin
      q_addr[wptr] <= mem_addr;
      q_data[wptr] <= mem_data;
    end
    if (alu_push) begin
      q_addr[wptr + AW'(mem_push)] <= alu_addr;
      q_data[wptr + AW'(mem_push)] <= alu_data;
    end
  end

`ifdef WBQ_BYPASS_EN
  function automatic logic [32:0] lookup(
    input logic [4:0] a
  );
    logic [32:0]   r;
    logic [AW-1:0] idx;
    r = '0;
    if (regWr && (addrWr == a))
      r = {1'b1, wr_data};
    // oldest to youngest, so the youngest match wins
    for (int j = 0; j < DEPTH; j++) begin
      idx = rptr + AW'(j);
      if ((CW'(j) < cnt) && (q_addr[idx] == a))
        r = {1'b1, q_data[idx]};
    end
    if (a == 5'd0)
      r = '0;
    return r;
  endfunction

  always_comb begin
    {byp_hit0, byp_data0} = lookup(byp_addr0);
    {byp_hit1, byp_data1} = lookup(byp_addr1);
  end
`else
  logic unused_byp;
  assign unused_byp = ^{byp_addr0, byp_addr1};
  assign byp_hit0   = 1'b0;
  assign byp_hit1   = 1'b0;
  assign byp_data0  = '0;
  assign byp_data1  = '0;
`endif

endmodule

// File: tb/tb_reg_wb_queue.sv
// Bench for reg_wb_queue: directed vector table plus
// randomized traffic against a queue-based reference model.
module tb_reg_wb_queue;

  localparam int DEPTH = 4;
`ifdef WBQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        mem_valid, mem_ready;
  logic [4:0]  mem_addr;
  logic [31:0] mem_data;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        regWr;
  logic [4:0]  addrWr;
  logic [31:0] wr_data;
  logic [4:0]  byp_addr0, byp_addr1;
  logic        byp_hit0, byp_hit1;
  logic [31:0] byp_data0, byp_data1;
  logic [2:0]  count;

  reg_wb_queue #(.DEPTH(4), .CW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_addr(alu_addr), .alu_data(alu_data),
    .regWr(regWr), .addrWr(addrWr), .wr_data(wr_data),
    .byp_addr0(byp_addr0), .byp_addr1(byp_addr1),
    .byp_hit0(byp_hit0), .byp_hit1(byp_hit1),
    .byp_data0(byp_data0), .byp_data1(byp_data1),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit rst; bit mv; logic [4:0] ma; logic [31:0] md;
    bit av; logic [4:0] aa; logic [31:0] ad;
    logic [4:0] b0; logic [4:0] b1;
    bit mr; bit ar; bit rw; logic [4:0] aw; logic [31:0] wd;
    logic [2:0] cnt;
    bit h0; logic [31:0] d0; bit h1; logic [31:0] d1;
  } vec_t;

  vec_t tv [23];

  typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;
  ent_t        q[$];
  bit          m_rw;
  logic [4:0]  m_aw;
  logic [31:0] m_wd;

  function automatic logic [32:0] mbyp(input logic [4:0] a);
    if (!BYP || a == 5'd0) return '0;
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].a == a) return {1'b1, q[i].d};
    if (m_rw && m_aw == a) return {1'b1, m_wd};
    return '0;
  endfunction

  task automatic drive(input vec_t v);
    rst_n = v.rst;
    mem_valid = v.mv; mem_addr = v.ma; mem_data = v.md;
    alu_valid = v.av; alu_addr = v.aa; alu_data = v.ad;
    byp_addr0 = v.b0; byp_addr1 = v.b1;
  endtask

  initial begin
    logic [32:0] eb;
    int          sz;
    bit          emr, ear, mp, ap;
    ent_t        e;

    tv[0]  = '{0,1,7,'h1,1,8,'h2,0,0, 0,0,0,0,'h0,0, 0,'h0,0,'h0};
    tv[1]  = '{1,0,0,0,0,0,0,0,0, 1,1,0,0,'h0,0, 0,'h0,0,'h0};
    tv[2]  = '{1,0,0,0,1,5,'h1234,0,0, 1,1,0,0,'h0,0, 0,'h0,0,'h0};
    tv[3]  = '{1,0,0,0,0,0,0,5,0, 1,1,0,0,'h0,1, 1,'h1234,0,'h0};
    tv[4]  = '{1,0,0,0,0,0,0,5,0, 1,1,1,5,'h1234,0, 1,'h1234,0,'h0};
    tv[5]  = '{1,0,0,0,0,0,0,5,0, 1,1,0,5,'h1234,0, 0,'h0,0,'h0};
    tv[6]  = '{1,1,3,'hAAAA,1,3,'hBBBB,3,0, 1,1,0,5,'h1234,0, 0,'h0,0,'h0};
    tv[7]  = '{1,0,0,0,0,0,0,3,0, 1,1,0,5,'h1234,2, 1,'hBBBB,0,'h0};
    tv[8]  = '{1,0,0,0,0,0,0,3,0, 1,1,1,3,'hAAAA,1, 1,'hBBBB,0,'h0};
    tv[9]  = '{1,0,0,0,0,0,0,3,0, 1,1,1,3,'hBBBB,0, 1,'hBBBB,0,'h0};
    tv[10] = '{1,0,0,0,0,0,0,3,0, 1,1,0,3,'hBBBB,0, 0,'h0,0,'h0};
    tv[11] = '{1,0,0,0,1,0,'hFFFF,0,0, 1,1,0,3,'hBBBB,0, 0,'h0,0,'h0};
    tv[12] = '{1,0,0,0,0,0,0,0,0, 1,1,0,3,'hBBBB,0, 0,'h0,0,'h0};
    tv[13] = '{1,0,0,0,0,0,0,0,0, 1,1,0,3,'hBBBB,0, 0,'h0,0,'h0};
    tv[14] = '{1,1,1,'h11,1,2,'h22,0,0, 1,1,0,3,'hBBBB,0, 0,'h0,0,'h0};
    tv[15] = '{1,1,3,'h33,1,4,'h44,2,1, 1,1,0,3,'hBBBB,2, 1,'h22,1,'h11};
    tv[16] = '{1,1,5,'h55,1,6,'h66,6,2, 1,0,1,1,'h11,3, 0,'h0,1,'h22};
    tv[17] = '{1,0,0,0,1,6,'h66,5,2, 1,1,1,2,'h22,3, 1,'h55,1,'h22};
    tv[18] = '{1,0,0,0,0,0,0,6,3, 1,1,1,3,'h33,3, 1,'h66,1,'h33};
    tv[19] = '{1,0,0,0,0,0,0,0,0, 1,1,1,4,'h44,2, 0,'h0,0,'h0};
    tv[20] = '{1,0,0,0,0,0,0,0,0, 1,1,1,5,'h55,1, 0,'h0,0,'h0};
    tv[21] = '{1,0,0,0,0,0,0,6,0, 1,1,1,6,'h66,0, 1,'h66,0,'h0};
    tv[22] = '{1,0,0,0,0,0,0,6,0, 1,1,0,6,'h66,0, 0,'h0,0,'h0};

    // two reset edges with both producers requesting
    drive(tv[0]);
    for (int i = 0; i < 2; i++) begin
      #1;
      chk($sformatf("rst%0d mem_ready", i), mem_ready, 0);
      chk($sformatf("rst%0d alu_ready", i), alu_ready, 0);
      @(posedge clk);
    end
    #1;

    for (int i = 0; i < 23; i++) begin
      drive(tv[i]);
      #1;
      chk($sformatf("v%0d mem_ready", i), mem_ready, tv[i].mr);
      chk($sformatf("v%0d alu_ready", i), alu_ready, tv[i].ar);
      chk($sformatf("v%0d regWr", i), regWr, tv[i].rw);
      chk($sformatf("v%0d addrWr", i), addrWr, tv[i].aw);
      chk($sformatf("v%0d wr_data", i), wr_data, tv[i].wd);
      chk($sformatf("v%0d count", i), count, tv[i].cnt);
      chk($sformatf("v%0d hit0", i), byp_hit0, BYP & tv[i].h0);
      chk($sformatf("v%0d data0", i), byp_data0,
          BYP ? tv[i].d0 : 32'h0);
      chk($sformatf("v%0d hit1", i), byp_hit1, BYP & tv[i].h1);
      chk($sformatf("v%0d data1", i), byp_data1,
          BYP ? tv[i].d1 : 32'h0);
      @(posedge clk);
      #1;
    end

    // reset both DUT and model, then random traffic
    rst_n = 1'b0; mem_valid = 1'b0; alu_valid = 1'b0;
    @(posedge clk);
    #1;
    q.delete(); m_rw = 0; m_aw = '0; m_wd = '0;
    mp = 0; ap = 0;

    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      if (!mp && $urandom_range(0, 2) != 0) begin
        mp = 1;
        mem_addr = 5'($urandom_range(0, 7));
        mem_data = $urandom;
      end
      if (!ap && $urandom_range(0, 2) != 0) begin
        ap = 1;
        alu_addr = 5'($urandom_range(0, 7));
        alu_data = $urandom;
      end
      mem_valid = mp;
      alu_valid = ap;
      byp_addr0 = 5'($urandom_range(0, 7));
      byp_addr1 = 5'($urandom_range(0, 7));
      #1;
      sz  = q.size();
      emr = rst_n && (sz < DEPTH);
      ear = rst_n && ((sz + 2 <= DEPTH) ||
                      (sz < DEPTH && !mem_valid));
      chk("rnd mem_ready", mem_ready, emr);
      chk("rnd alu_ready", alu_ready, ear);
      chk("rnd regWr", regWr, m_rw);
      if (m_rw) begin
        chk("rnd addrWr", addrWr, m_aw);
        chk("rnd wr_data", wr_data, m_wd);
      end
      chk("rnd count", count, sz);
      eb = mbyp(byp_addr0);
      chk("rnd hit0", byp_hit0, eb[32]);
      chk("rnd data0", byp_data0, eb[31:0]);
      eb = mbyp(byp_addr1);
      chk("rnd hit1", byp_hit1, eb[32]);
      chk("rnd data1", byp_data1, eb[31:0]);
      @(posedge clk);
      if (!rst_n) begin
        q.delete(); m_rw = 0; m_aw = '0; m_wd = '0;
      end else begin
        if (sz > 0) begin
          e = q.pop_front();
          m_rw = 1; m_aw = e.a; m_wd = e.d;
        end else begin
          m_rw = 0;
        end
        if (mem_valid && emr) begin
          if (mem_addr != 0) q.push_back('{mem_addr, mem_data});
          mp = 0;
        end
        if (alu_valid && ear) begin
          if (alu_addr != 0) q.push_back('{alu_addr, alu_data});
          ap = 0;
        end
      end
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
